// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and constants for the eight-digit multiplexed display scanner.
package display_scan_ctrl_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned SEL_W      = 3;
    localparam int unsigned FRAME_W    = NUM_DIGITS * DIGIT_W;
    localparam int unsigned CNT_W      = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    typedef struct packed {
        logic [FRAME_W-1:0]    digits;
        logic [NUM_DIGITS-1:0] blank;
    } frame_t;

    // Explicit blank mask OR'd with leading-zero suppression (digit 0 always kept).
    function automatic logic [NUM_DIGITS-1:0] blank_mask(
        input logic [FRAME_W-1:0]    digits,
        input logic [NUM_DIGITS-1:0] blank,
        input logic                  lz
    );
        logic                  lead;
        logic [NUM_DIGITS-1:0] mask;
        lead = lz;
        mask = blank;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            lead = lead && (digits[i*DIGIT_W +: DIGIT_W] == '0);
            if (lead) mask[i] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_scan_timer.sv
// Loadable down-counter; expired_c is high once the count reaches zero.
module scan_timer
    import display_scan_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired_c
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expired_c = (count == '0);

endmodule

// File: rtl/display_scan_ctrl.sv
// Eight-digit display scanner: frame handshake, frame-boundary commit,
// SHOW/GUARD dwell timing and leading-zero blanking.
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int unsigned CLK_DIV = 100000,
    parameter int unsigned GUARD   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  upd_valid,
    output logic                  upd_ready,
    input  logic [FRAME_W-1:0]    upd_digits,
    input  logic [NUM_DIGITS-1:0] upd_blank,
    input  logic                  lz_suppress,
    output logic [DIGIT_W-1:0]    digit_val,
    output logic [SEL_W-1:0]      digit_sel,
    output logic                  digit_en,
    output logic                  frame_done
);

    localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LOAD = (GUARD == 0) ? '0 : CNT_W'(GUARD - 1);

    state_t                state;
    state_t                state_nxt;
    logic [SEL_W-1:0]      sel_nxt;
    logic                  tmr_load;
    logic [CNT_W-1:0]      tmr_val;
    logic                  tmr_expired_c;
    logic                  advance_c;
    logic                  wrap_c;
    logic                  transfer_c;
    logic                  commit_c;
    logic                  pend_valid;
    logic                  pend_valid_nxt;
    frame_t                pend;
    frame_t                disp;
    frame_t                disp_nxt;
    logic [NUM_DIGITS-1:0] blank_c;

    scan_timer u_scan_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (tmr_load),
        .load_val  (tmr_val),
        .expired_c (tmr_expired_c)
    );

    // Next state, timer reload and digit advance; disabling overrides everything.
    always_comb begin
        state_nxt = state;
        sel_nxt   = digit_sel;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        advance_c = 1'b0;
        if (!enable) begin
            state_nxt = ST_IDLE;
            tmr_load  = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_SHOW;
                    tmr_load  = 1'b1;
                    tmr_val   = SHOW_LOAD;
                end
                ST_SHOW: begin
                    if (tmr_expired_c) begin
                        tmr_load = 1'b1;
                        if (GUARD == 0) begin
                            advance_c = 1'b1;
                            tmr_val   = SHOW_LOAD;
                        end else begin
                            state_nxt = ST_GUARD;
                            tmr_val   = GUARD_LOAD;
                        end
                    end
                end
                ST_GUARD: begin
                    if (tmr_expired_c) begin
                        state_nxt = ST_SHOW;
                        advance_c = 1'b1;
                        tmr_load  = 1'b1;
                        tmr_val   = SHOW_LOAD;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
        if (advance_c) sel_nxt = digit_sel + SEL_W'(1);
    end

    // Pending data only reaches the display at a frame wrap or while dark.
    assign wrap_c         = advance_c && (digit_sel == SEL_W'(NUM_DIGITS - 1));
    assign transfer_c     = upd_valid && upd_ready;
    assign commit_c       = pend_valid && (wrap_c || !enable);
    assign pend_valid_nxt = transfer_c || (pend_valid && !commit_c);
    assign disp_nxt       = commit_c ? pend : disp;
    assign blank_c        = blank_mask(disp_nxt.digits, disp_nxt.blank, lz_suppress);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            digit_sel  <= '0;
            digit_val  <= '0;
            digit_en   <= 1'b0;
            frame_done <= 1'b0;
            upd_ready  <= 1'b1;
            pend_valid <= 1'b0;
            pend       <= '0;
            disp       <= '{digits: '0, blank: '1};
        end else begin
            state      <= state_nxt;
            digit_sel  <= sel_nxt;
            digit_val  <= disp_nxt.digits[sel_nxt*DIGIT_W +: DIGIT_W];
            digit_en   <= (state_nxt == ST_SHOW) && !blank_c[sel_nxt];
            frame_done <= wrap_c;
            upd_ready  <= !pend_valid_nxt;
            pend_valid <= pend_valid_nxt;
            disp       <= disp_nxt;
            if (transfer_c) begin
                pend <= '{digits: upd_digits, blank: upd_blank};
            end
        end
    end

endmodule
